// File: rtl/dynamic_clock_divider_mc_if.sv
// Control and status bundle for the multi-channel clock divider.
// Channel n owns bit n of every vector and slice n of i_DIV_VALUE.
interface dynamic_clock_divider_mc_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       i_ENABLE;
  logic [CHANNELS-1:0]       i_MODE;
  logic [CHANNELS*WIDTH-1:0] i_DIV_VALUE;
  logic [CHANNELS-1:0]       i_LOAD;
  logic [CHANNELS-1:0]       o_ENABLE_OUT;
  logic [CHANNELS-1:0]       o_SQUARE_OUT;
  logic [CHANNELS-1:0]       o_LOAD_ACK;

  modport master (
    output i_ENABLE, i_MODE, i_DIV_VALUE, i_LOAD,
    input  o_ENABLE_OUT, o_SQUARE_OUT, o_LOAD_ACK
  );

  modport slave (
    input  i_ENABLE, i_MODE, i_DIV_VALUE, i_LOAD,
    output o_ENABLE_OUT, o_SQUARE_OUT, o_LOAD_ACK
  );
endinterface

// File: rtl/dynamic_clock_divider_mc.sv
// Multi-channel clock-enable generator. Each channel counts 0..r_div and
// emits a one-cycle strobe plus a square wave toggling once per period.
// A new divider is staged in r_pend and only swapped into r_div at a
// period boundary (or while the channel is idle), so no period is ever
// truncated or stretched.
module dynamic_clock_divider_mc #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int RESET_DIV = 1
) (
  input  logic i_CLK,
  input  logic i_RESET_N,
  dynamic_clock_divider_mc_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_v;
    logic             r_strobe;
    logic             r_square;
    logic             r_ack;
    logic [WIDTH-1:0] w_slice;
    logic             w_wrap;
    logic             w_apply;

    assign w_slice = bus.i_DIV_VALUE[n*WIDTH +: WIDTH];
    // Period boundary is judged against the active divider only.
    assign w_wrap  = bus.i_ENABLE[n] && (r_count == r_div);
    // An idle channel has no period in flight, so it may take the value at once.
    assign w_apply = r_pend_v && (w_wrap || !bus.i_ENABLE[n]);

    // Counter, outputs and double-buffered divider for one channel.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
        r_count  <= '0;
        r_div    <= RST_DIV;
        r_pend   <= '0;
        r_pend_v <= 1'b0;
        r_strobe <= 1'b0;
        r_square <= 1'b0;
        r_ack    <= 1'b0;
      end else begin
        if (!bus.i_ENABLE[n] || w_wrap) begin
          r_count <= '0;
        end else begin
          r_count <= r_count + WIDTH'(1);
        end

        r_strobe <= w_wrap;

        if (!bus.i_ENABLE[n] || !bus.i_MODE[n]) begin
          r_square <= 1'b0;
        end else if (w_wrap) begin
          r_square <= ~r_square;
        end

        if (w_apply) begin
          r_div <= r_pend;
          r_ack <= 1'b1;
        end else begin
          r_ack <= 1'b0;
        end

        // A load in the same cycle as an apply becomes the next pending value.
        if (bus.i_LOAD[n]) begin
          r_pend   <= w_slice;
          r_pend_v <= 1'b1;
        end else if (w_apply) begin
          r_pend_v <= 1'b0;
        end
      end
    end

    assign bus.o_ENABLE_OUT[n] = r_strobe;
    assign bus.o_SQUARE_OUT[n] = r_square;
    assign bus.o_LOAD_ACK[n]   = r_ack;
  end

endmodule

// File: doc/dynamic_clock_divider_mc.md
# dynamic_clock_divider_mc

Multi-channel, parametrised clock-enable generator. Each of CHANNELS independent channels divides i_CLK by a programmable value and produces a one-cycle strobe and a 50 % duty square wave. Divider values are double-buffered: a new value is staged and applied only at a period boundary, so the outputs never emit a truncated or stretched period. It sits beside the single-channel divider and feeds per-peripheral tick enables (UART baud, PWM base, LED scan) from one system clock.

## Interface
- WIDTH, 32: counter and divider width per channel.
- CHANNELS, 4: number of independent channels.
- RESET_DIV, 1: active divider value of every channel after reset.
- i_CLK  in  1  single system clock; all logic on its rising edge.
- i_RESET_N  in  1  reset, asynchronous, active-low; release is synchronous to i_CLK upstream.
- i_ENABLE  in  CHANNELS  per-channel run enable.
- i_MODE  in  CHANNELS  reserved select for the square output: 0 = square forced low, 1 = square active.
- i_DIV_VALUE  in  CHANNELS*WIDTH  staged divider; channel n uses bits [n*WIDTH +: WIDTH].
- i_LOAD  in  CHANNELS  one-cycle request to stage i_DIV_VALUE slice n for channel n.
- o_ENABLE_OUT  out  CHANNELS  one-cycle strobe per period.
- o_SQUARE_OUT  out  CHANNELS  toggles once per period (period 2*(div+1)).
- o_LOAD_ACK  out  CHANNELS  one-cycle pulse when a staged value becomes active.

## Operation
- Per-channel registers: r_count[WIDTH], r_div[WIDTH] (active), r_pend[WIDTH], r_pend_v, plus the three outputs.
- Reset (i_RESET_N low, asynchronous): r_count=0, r_div=RESET_DIV, r_pend=0, r_pend_v=0, all outputs 0.
- wrap(n) = i_ENABLE[n] && r_count==r_div. Comparison always uses r_div, never the live input.
- Counter: i_ENABLE=0 -> r_count=0; wrap -> r_count=0; else r_count+1 (WIDTH bits, no overflow, as r_count ≤ r_div).
- o_ENABLE_OUT[n] <= wrap(n). Strobe period is r_div+1 cycles; r_div=0 gives a continuous high.
- o_SQUARE_OUT[n]: i_ENABLE=0 or i_MODE=0 -> 0; on wrap toggles; else holds.
- Staging: i_LOAD[n] -> r_pend <= slice, r_pend_v <= 1. A second load before application overwrites r_pend; only one ack results.
- Apply: if r_pend_v && (wrap(n) || !i_ENABLE[n]) -> r_div <= r_pend, o_LOAD_ACK[n] <= 1, r_pend_v <= 0 (unless i_LOAD[n] same cycle, then new value becomes pending, r_pend_v stays 1). Otherwise o_LOAD_ACK <= 0.
- Load and wrap in same cycle with nothing pending: value is staged, applied at the next wrap, not the current one.
- Channels share nothing but clock and reset; no cross-channel interaction.

## Timing
- Strobe latency: o_ENABLE_OUT rises the cycle after r_count reaches r_div; first strobe after i_ENABLE rises appears r_div+1 cycles after the first enabled edge.
- New divider: first period using the new value starts on the edge that asserts o_LOAD_ACK; old period is always completed.
- i_ENABLE drop: next edge r_count=0, o_ENABLE_OUT=0, o_SQUARE_OUT=0; pending value applied on that edge with ack.
- Reset mid-period: outputs go 0 immediately (asynchronous), pending value discarded, no ack.
- i_MODE change takes effect the next edge; it does not affect counter or strobe.

## Test plan
- Reset, RESET_DIV=1, ch0 enable, mode=1 -> o_ENABLE_OUT[0] high every 2nd cycle, o_SQUARE_OUT[0] period 4, other channels stay 0.
- ch1 div staged 4 then enabled -> strobe every 5 cycles; at count=2 load 9 -> current period ends at 5 cycles, o_LOAD_ACK[1] on that edge, next strobes every 10 cycles.
- ch2 two loads (7 then 3) within one period -> single ack, active div 3; load coinciding with wrap and nothing pending -> applied one full period later.
- ch3 div 0 -> o_ENABLE_OUT[3] constant 1, square toggles every cycle; drop enable -> both 0 next edge, count 0.
- Disabled channel with load 6 -> ack next edge, r_div=6; enable -> first strobe 7 cycles later.
- Assert i_RESET_N low between edges mid-period with pending value -> outputs 0 without clock edge, after release r_div=RESET_DIV, no ack.
